scared_mode_controller: RTL and testbench

Generates the power-pellet frightened period for the game: loads and counts down `scared_mode_timer`, drives `scared_mode` and a ghost-flash warning, and scores ghosts eaten during the period. It sits upstream of the life/collision controller, which consumes `scared_mode`/`scared_mode_timer`. It also consumes that controller's per-ghost `*_dead` codes and feeds ghost-eat points to the score block.

---
 rtl/scared_mode_controller_pkg.sv | 51 +++++
 rtl/scared_mode_controller_ghost_eat_scorer.sv | 120 ++++++++++++
 rtl/scared_mode_controller.sv | 168 ++++++++++++++++
 tb/tb_scared_mode_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scared_mode_controller_pkg.sv
// -----------------------------------------------------------------------------
// scared_mode_controller_pkg
// Shared game parameters for the maze game: frightened-mode FSM encodings,
// ghost status codes, frightened timing defaults, scoring constants and the
// tile/screen geometry used by the rest of the video and game blocks.
// -----------------------------------------------------------------------------
package scared_mode_controller_pkg;

    // Frightened-period FSM encoding (the life controller decodes the same values)
    typedef enum logic [1:0] {
        SM_IDLE   = 2'd0,
        SM_SCARED = 2'd1,
        SM_EXPIRE = 2'd2
    } scared_state_e;

    // Per-ghost status codes driven by the life/collision controller
    localparam logic [1:0] GHOST_ALIVE = 2'd0;
    localparam logic [1:0] GHOST_EYES  = 2'd1;
    localparam logic [1:0] GHOST_HOME  = 2'd2;

    // Frightened-period defaults
    localparam int DEFAULT_SCARED_SECONDS = 8;
    localparam int DEFAULT_FLASH_SECONDS  = 3;
    localparam int DEFAULT_BASE_POINTS    = 200;

    // Datapath widths and limits
    localparam int         GHOST_COUNT      = 4;
    localparam int         TIMER_W          = 4;
    localparam int         POINTS_W         = 12;
    localparam int         EATEN_W          = 3;
    localparam logic [2:0] MAX_GHOSTS_EATEN = 3'd4;

    // Tile and screen geometry
    localparam int TILE_SIZE     = 8;
    localparam int MAZE_TILES_X  = 28;
    localparam int MAZE_TILES_Y  = 36;
    localparam int SCREEN_WIDTH  = 224;
    localparam int SCREEN_HEIGHT = 288;

    // Ghost-eat value doubles with each ghost already eaten this period
    function automatic logic [11:0] ghost_points(input logic [11:0] base,
                                                 input logic [2:0]  eaten);
        ghost_points = base << eaten;
    endfunction

    // Isolates the lowest set bit of a 4-bit mask (one-hot, or zero if empty)
    function automatic logic [3:0] lowest_set(input logic [3:0] mask);
        lowest_set = mask & (~mask + 4'd1);
    endfunction

endpackage

// File: rtl/scared_mode_controller_ghost_eat_scorer.sv
// -----------------------------------------------------------------------------
// ghost_eat_scorer
// Detects ghosts being eaten (status code alive -> eyes while frightened and
// Pac-Man alive), queues them in a pending mask, and serves one per cycle
// (lowest ghost index first) as a score pulse worth BASE_POINTS << eaten.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   scared_mode         registered frightened flag from the parent FSM
//   pacman_dead         death level; flushes the pending mask, blocks scoring
//   clear_eaten         pellet reload: restart the per-period ghost count
//   *_dead [1:0]        ghost status codes (blinky=0 .. clyde=3)
//   score_add_valid     one-cycle score pulse
//   score_add [11:0]    points, valid with score_add_valid
//   ghosts_eaten [2:0]  ghosts eaten this period, saturating at 4
// -----------------------------------------------------------------------------
import scared_mode_controller_pkg::*;

module ghost_eat_scorer #(
    parameter int BASE_POINTS = DEFAULT_BASE_POINTS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scared_mode,
    input  logic        pacman_dead,
    input  logic        clear_eaten,
    input  logic [1:0]  blinky_dead,
    input  logic [1:0]  pinky_dead,
    input  logic [1:0]  inky_dead,
    input  logic [1:0]  clyde_dead,
    output logic        score_add_valid,
    output logic [11:0] score_add,
    output logic [2:0]  ghosts_eaten
);

    localparam logic [11:0] BASE_VAL = 12'(BASE_POINTS);

    logic [3:0][1:0] code_s;
    logic [3:0][1:0] prev_q;
    logic [3:0][1:0] prev_d;
    logic [3:0]      eat_s;
    logic [3:0]      pend_all_s;
    logic [3:0]      serve_sel_s;
    logic [3:0]      pending_q;
    logic [3:0]      pending_d;
    logic            score_add_valid_q;
    logic            score_add_valid_d;
    logic [11:0]     score_add_q;
    logic [11:0]     score_add_d;
    logic [2:0]      ghosts_eaten_q;
    logic [2:0]      ghosts_eaten_d;

    assign code_s = {clyde_dead, inky_dead, pinky_dead, blinky_dead};

    // Edge detection, pending-mask update and single-ghost-per-cycle service
    always_comb begin
        eat_s             = 4'b0000;
        prev_d            = code_s;
        pending_d         = pending_q;
        score_add_valid_d = 1'b0;
        score_add_d       = 12'd0;
        ghosts_eaten_d    = ghosts_eaten_q;

        for (int i = 0; i < GHOST_COUNT; i++) begin
            eat_s[i] = (prev_q[i] == GHOST_ALIVE) && (code_s[i] == GHOST_EYES) &&
                       scared_mode && !pacman_dead;
        end

        // A fresh eat is visible to the server in the same cycle it is
        // detected, so a lone eat scores without an extra cycle of latency.
        pend_all_s  = pending_q | eat_s;
        serve_sel_s = lowest_set(pend_all_s);

        if (pacman_dead) begin
            pending_d = 4'b0000;
        end else begin
            pending_d = pend_all_s & ~serve_sel_s;
            if (pend_all_s != 4'b0000) begin
                score_add_valid_d = 1'b1;
                score_add_d       = ghost_points(BASE_VAL, ghosts_eaten_q);
                if (ghosts_eaten_q >= MAX_GHOSTS_EATEN) begin
                    ghosts_eaten_d = MAX_GHOSTS_EATEN;
                end else begin
                    ghosts_eaten_d = ghosts_eaten_q + 3'd1;
                end
            end else begin
                score_add_valid_d = 1'b0;
            end
        end

        // A pellet reload starts a new doubling sequence.
        if (clear_eaten) begin
            ghosts_eaten_d = 3'd0;
        end else begin
            ghosts_eaten_d = ghosts_eaten_d;
        end
    end

    // Scorer state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q            <= '0;
            pending_q         <= 4'b0000;
            score_add_valid_q <= 1'b0;
            score_add_q       <= 12'd0;
            ghosts_eaten_q    <= 3'd0;
        end else begin
            prev_q            <= prev_d;
            pending_q         <= pending_d;
            score_add_valid_q <= score_add_valid_d;
            score_add_q       <= score_add_d;
            ghosts_eaten_q    <= ghosts_eaten_d;
        end
    end

    assign score_add_valid = score_add_valid_q;
    assign score_add       = score_add_q;
    assign ghosts_eaten    = ghosts_eaten_q;

endmodule

// File: rtl/scared_mode_controller.sv
// -----------------------------------------------------------------------------
// scared_mode_controller
// Power-pellet frightened period: loads and counts down the seconds timer,
// drives scared_mode and the ghost flash warning, and (through
// ghost_eat_scorer) scores ghosts eaten during the period.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   one_hz_enable           one-cycle 1 Hz tick
//   pellet_eaten            one-cycle power-pellet pulse
//   pacman_dead             death level from the life controller
//   *_dead [1:0]            ghost status codes (0 alive, 1 eyes, 2 home)
//   scared_mode             frightened period active (includes EXPIRE cycle)
//   scared_mode_timer [3:0] seconds remaining
//   scared_flash            ghost sprite alternate-colour select
//   score_add_valid         one-cycle score pulse
//   score_add [11:0]        points to add
//   ghosts_eaten [2:0]      ghosts eaten this period
// -----------------------------------------------------------------------------
import scared_mode_controller_pkg::*;

module scared_mode_controller #(
    parameter int SCARED_SECONDS = DEFAULT_SCARED_SECONDS,
    parameter int FLASH_SECONDS  = DEFAULT_FLASH_SECONDS,
    parameter int BASE_POINTS    = DEFAULT_BASE_POINTS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        one_hz_enable,
    input  logic        pellet_eaten,
    input  logic        pacman_dead,
    input  logic [1:0]  blinky_dead,
    input  logic [1:0]  pinky_dead,
    input  logic [1:0]  inky_dead,
    input  logic [1:0]  clyde_dead,
    output logic        scared_mode,
    output logic [3:0]  scared_mode_timer,
    output logic        scared_flash,
    output logic        score_add_valid,
    output logic [11:0] score_add,
    output logic [2:0]  ghosts_eaten
);

    localparam logic [3:0] LOAD_VAL  = 4'(SCARED_SECONDS);
    localparam logic [3:0] FLASH_VAL = 4'(FLASH_SECONDS);

    scared_state_e state_q;
    scared_state_e state_d;
    logic [3:0]    timer_q;
    logic [3:0]    timer_d;
    logic          phase_q;
    logic          phase_d;
    logic          scared_mode_q;
    logic          scared_mode_d;
    logic          scared_flash_q;
    logic          scared_flash_d;
    logic          tick_s;
    logic          reload_s;
    logic          in_flash_s;
    logic          clear_eaten_s;

    // Next-state, timer and flash-phase computation
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        tick_s   = 1'b0;
        reload_s = 1'b0;

        // Priority: death, then pellet, then normal sequencing.
        if (pacman_dead) begin
            state_d = SM_IDLE;
            timer_d = 4'd0;
        end else if (pellet_eaten) begin
            state_d  = SM_SCARED;
            timer_d  = LOAD_VAL;
            reload_s = 1'b1;
        end else begin
            case (state_q)
                SM_IDLE: begin
                    state_d = SM_IDLE;
                    timer_d = 4'd0;
                end
                SM_SCARED: begin
                    if (one_hz_enable) begin
                        tick_s = 1'b1;
                        // <= also catches the unreachable zero timer safely
                        if (timer_q <= 4'd1) begin
                            state_d = SM_EXPIRE;
                            timer_d = 4'd0;
                        end else begin
                            state_d = SM_SCARED;
                            timer_d = timer_q - 4'd1;
                        end
                    end else begin
                        state_d = SM_SCARED;
                        timer_d = timer_q;
                    end
                end
                SM_EXPIRE: begin
                    state_d = SM_IDLE;
                    timer_d = 4'd0;
                end
                default: begin
                    state_d = SM_IDLE;
                    timer_d = 4'd0;
                end
            endcase
        end

        // Flash decisions use the next timer value, so the warning lights up
        // in the same cycle the displayed timer reaches FLASH_SECONDS.
        in_flash_s = (state_d == SM_SCARED) && (timer_d <= FLASH_VAL);
        if (in_flash_s && !reload_s) begin
            if (tick_s) begin
                phase_d = ~phase_q;
            end else begin
                phase_d = phase_q;
            end
        end else begin
            phase_d = 1'b0;
        end

        scared_flash_d = in_flash_s && phase_d;
        scared_mode_d  = (state_d != SM_IDLE);
    end

    // FSM state and registered frightened-mode outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= SM_IDLE;
            timer_q        <= 4'd0;
            phase_q        <= 1'b0;
            scared_mode_q  <= 1'b0;
            scared_flash_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            phase_q        <= phase_d;
            scared_mode_q  <= scared_mode_d;
            scared_flash_q <= scared_flash_d;
        end
    end

    // A pellet that is overridden by death does not start a new period.
    assign clear_eaten_s = pellet_eaten & ~pacman_dead;

    ghost_eat_scorer #(
        .BASE_POINTS (BASE_POINTS)
    ) u_ghost_eat_scorer (
        .clk             (clk),
        .reset           (reset),
        .scared_mode     (scared_mode_q),
        .pacman_dead     (pacman_dead),
        .clear_eaten     (clear_eaten_s),
        .blinky_dead     (blinky_dead),
        .pinky_dead      (pinky_dead),
        .inky_dead       (inky_dead),
        .clyde_dead      (clyde_dead),
        .score_add_valid (score_add_valid),
        .score_add       (score_add),
        .ghosts_eaten    (ghosts_eaten)
    );

    assign scared_mode       = scared_mode_q;
    assign scared_mode_timer = timer_q;
    assign scared_flash      = scared_flash_q;

endmodule

// File: tb/tb_scared_mode_controller.sv
// -----------------------------------------------------------------------------
// tb_scared_mode_controller
// Directed scenarios followed by random play, checked every cycle against a
// behavioural model of the frightened period and ghost scoring.
// -----------------------------------------------------------------------------
module tb_scared_mode_controller;

    localparam int SEC   = 8;
    localparam int FLASH = 3;
    localparam int BASE  = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        one_hz_enable;
    logic        pellet_eaten;
    logic        pacman_dead;
    logic [1:0]  blinky_dead;
    logic [1:0]  pinky_dead;
    logic [1:0]  inky_dead;
    logic [1:0]  clyde_dead;
    logic        scared_mode;
    logic [3:0]  scared_mode_timer;
    logic        scared_flash;
    logic        score_add_valid;
    logic [11:0] score_add;
    logic [2:0]  ghosts_eaten;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    bit       m_scared;
    bit       m_expire;
    int       m_timer;
    bit       m_phase;
    bit       m_flash;
    int       m_eaten;
    bit [3:0] m_pend;
    int       m_prev[4];
    bit       m_valid;
    int       m_add;

    scared_mode_controller dut (
        .clk               (clk),
        .reset             (reset),
        .one_hz_enable     (one_hz_enable),
        .pellet_eaten      (pellet_eaten),
        .pacman_dead       (pacman_dead),
        .blinky_dead       (blinky_dead),
        .pinky_dead        (pinky_dead),
        .inky_dead         (inky_dead),
        .clyde_dead        (clyde_dead),
        .scared_mode       (scared_mode),
        .scared_mode_timer (scared_mode_timer),
        .scared_flash      (scared_flash),
        .score_add_valid   (score_add_valid),
        .score_add         (score_add),
        .ghosts_eaten      (ghosts_eaten)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scared = 1'b0;
        m_expire = 1'b0;
        m_timer  = 0;
        m_phase  = 1'b0;
        m_flash  = 1'b0;
        m_eaten  = 0;
        m_pend   = 4'b0000;
        m_valid  = 1'b0;
        m_add    = 0;
        for (int i = 0; i < 4; i++) m_prev[i] = 0;
    endtask

    // One clock of the frightened-period rules, applied to the inputs present at the edge
    task automatic model_step();
        int codes[4];
        int sel;
        bit mode_out;
        codes[0] = int'(blinky_dead);
        codes[1] = int'(pinky_dead);
        codes[2] = int'(inky_dead);
        codes[3] = int'(clyde_dead);
        mode_out = m_scared || m_expire;

        for (int i = 0; i < 4; i++)
            if (m_prev[i] == 0 && codes[i] == 1 && mode_out && !pacman_dead) m_pend[i] = 1'b1;
        m_valid = 1'b0;
        m_add   = 0;
        if (pacman_dead) begin
            m_pend = 4'b0000;
        end else begin
            sel = -1;
            for (int i = 3; i >= 0; i--) if (m_pend[i]) sel = i;
            if (sel >= 0) begin
                m_valid = 1'b1;
                m_add   = BASE * (2 ** m_eaten);
                m_pend[sel] = 1'b0;
                if (m_eaten < 4) m_eaten++;
            end
        end
        if (pellet_eaten && !pacman_dead) m_eaten = 0;
        for (int i = 0; i < 4; i++) m_prev[i] = codes[i];

        if (pacman_dead) begin
            m_scared = 1'b0; m_expire = 1'b0; m_timer = 0;
        end else if (pellet_eaten) begin
            m_scared = 1'b1; m_expire = 1'b0; m_timer = SEC; m_phase = 1'b0;
        end else if (m_expire) begin
            m_expire = 1'b0;
        end else if (m_scared && one_hz_enable) begin
            m_timer = m_timer - 1;
            if (m_timer == 0) begin
                m_scared = 1'b0; m_expire = 1'b1;
            end else if (m_timer <= FLASH) begin
                m_phase = !m_phase;
            end
        end
        if (!m_scared || m_timer > FLASH) m_phase = 1'b0;
        m_flash = m_scared && (m_timer <= FLASH) && m_phase;
    endtask

    task automatic check_all();
        chk("scared_mode", 32'(scared_mode), 32'(m_scared || m_expire));
        chk("timer", 32'(scared_mode_timer), 32'(m_timer));
        chk("flash", 32'(scared_flash), 32'(m_flash));
        chk("score_valid", 32'(score_add_valid), 32'(m_valid));
        chk("score_add", 32'(score_add), 32'(m_add));
        chk("ghosts_eaten", 32'(ghosts_eaten), 32'(m_eaten));
    endtask

    task automatic cyc(input bit p, input bit t);
        pellet_eaten  = p;
        one_hz_enable = t;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        pellet_eaten  = 1'b0;
        one_hz_enable = 1'b0;
    endtask

    task automatic set_codes(input logic [1:0] b, input logic [1:0] p,
                             input logic [1:0] i, input logic [1:0] c);
        blinky_dead = b; pinky_dead = p; inky_dead = i; clyde_dead = c;
    endtask

    initial begin
        reset = 1'b1;
        one_hz_enable = 1'b0;
        pellet_eaten  = 1'b0;
        pacman_dead   = 1'b0;
        set_codes(2'd0, 2'd0, 2'd0, 2'd0);
        model_reset();
        #12;
        check_all();
        @(posedge clk);
        #1 reset = 1'b0;

        // Full countdown with flash warning
        cyc(1'b1, 1'b0);
        chk("pellet_timer", 32'(scared_mode_timer), 32'd8);
        for (int k = 0; k < SEC; k++) begin
            cyc(1'b0, 1'b1);
            if (k == 4) chk("flash_at_3", 32'(scared_flash), 32'd1);
            if (k == SEC - 1) begin
                chk("expire_mode", 32'(scared_mode), 32'd1);
                chk("expire_timer", 32'(scared_mode_timer), 32'd0);
            end
            cyc(1'b0, 1'b0);
            if (k == SEC - 1) chk("after_expire", 32'(scared_mode), 32'd0);
        end

        // Reload at timer 4 restarts the ghost count
        cyc(1'b1, 1'b0);
        set_codes(2'd1, 2'd0, 2'd0, 2'd0);
        cyc(1'b0, 1'b0);
        chk("first_eat", 32'(score_add), 32'd200);
        set_codes(2'd2, 2'd0, 2'd0, 2'd0);
        cyc(1'b0, 1'b0);
        set_codes(2'd0, 2'd0, 2'd0, 2'd0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1);
        chk("timer_4", 32'(scared_mode_timer), 32'd4);
        cyc(1'b1, 1'b0);
        chk("reload_eaten", 32'(ghosts_eaten), 32'd0);
        chk("reload_timer", 32'(scared_mode_timer), 32'd8);

        // Sequential and simultaneous eats
        set_codes(2'd1, 2'd0, 2'd0, 2'd0);
        cyc(1'b0, 1'b0);
        chk("blinky_pts", 32'(score_add), 32'd200);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        set_codes(2'd1, 2'd1, 2'd0, 2'd0);
        cyc(1'b0, 1'b0);
        chk("pinky_pts", 32'(score_add), 32'd400);
        chk("eaten_2", 32'(ghosts_eaten), 32'd2);
        set_codes(2'd1, 2'd1, 2'd1, 2'd1);
        cyc(1'b0, 1'b0);
        chk("inky_pts", 32'(score_add), 32'd800);
        cyc(1'b0, 1'b0);
        chk("clyde_pts", 32'(score_add), 32'd1600);
        chk("eaten_4", 32'(ghosts_eaten), 32'd4);
        cyc(1'b0, 1'b0);

        // Death beats a simultaneous pellet and a simultaneous eat
        set_codes(2'd0, 2'd0, 2'd0, 2'd0);
        cyc(1'b1, 1'b0);
        set_codes(2'd1, 2'd0, 2'd0, 2'd0);
        pacman_dead = 1'b1;
        cyc(1'b1, 1'b0);
        chk("dead_mode", 32'(scared_mode), 32'd0);
        chk("dead_timer", 32'(scared_mode_timer), 32'd0);
        chk("dead_valid", 32'(score_add_valid), 32'd0);
        pacman_dead = 1'b0;
        set_codes(2'd0, 2'd0, 2'd0, 2'd0);
        cyc(1'b0, 1'b0);

        // Asynchronous reset mid-period
        cyc(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1);
        chk("timer_5", 32'(scared_mode_timer), 32'd5);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all();
        one_hz_enable = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1);

        // Random play
        for (int k = 0; k < 3000; k++) begin
            pacman_dead = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) blinky_dead = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) pinky_dead  = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) inky_dead   = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) clyde_dead  = 2'($urandom_range(0, 2));
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
